fetch_align: RTL

FETCH_ALIGN -- requirements
Module: fetch_align

---
 rtl/fetch_align.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/fetch_align.sv
// rtl/fetch_align.sv - aligns 16/32-bit instructions out of 64-bit SRAM fetch lines
//
// Purpose:
//   Takes 64-bit instruction lines returned one cycle after isram_cs and
//   presents the instruction at pc to decode. 16-bit compressed instructions
//   are zero-extended. A 32-bit instruction starting in the top halfword of a
//   line has its lower half buffered (cross_wait=1) until the next line
//   arrives, which supplies the upper half.
//
// Ports:
//   clk                 in   core clock, rising edge
//   cpurst_n            in   asynchronous active-low reset
//   isram_cs            in   SRAM read strobe; data returns next cycle
//   isram_rdata[63:0]   in   SRAM read line
//   pc[31:0]            in   address of the instruction presented this cycle
//   branch_predict_err  in   flush; drops buffered fetch state
//   de_stall            in   decode stall; holds alignment state
//   rv32_instr[31:0]    out  aligned instruction (NOP when not valid)
//   isrv16              out  rv32_instr is a zero-extended compressed instruction
//   instr_valid         out  rv32_instr valid this cycle
//   fetch_misalign      out  pc[0]=1 while a line is available
//   cross_wait          out  lower half of a line-crossing instruction is buffered

module fetch_align (
    input  logic        clk,
    input  logic        cpurst_n,
    input  logic        isram_cs,
    input  logic [63:0] isram_rdata,
    input  logic [31:0] pc,
    input  logic        branch_predict_err,
    input  logic        de_stall,
    output logic [31:0] rv32_instr,
    output logic        isrv16,
    output logic        instr_valid,
    output logic        fetch_misalign,
    output logic        cross_wait
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_XBD  = 2'd2;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic [1:0]  r_state;
    logic        r_rdata_vld;
    logic        r_line_vld;
    logic [63:0] r_line_ff;
    logic [15:0] r_hw_buf;

    logic [63:0] w_line;
    logic        w_avail;
    logic [1:0]  w_slot;
    logic [63:0] w_line_shift;
    logic [15:0] w_hw;
    logic        w_is16;
    logic        w_cross;
    logic        w_misalign;
    logic [1:0]  w_next_state;
    logic        w_hw_load;
    logic [31:0] w_instr;
    logic        w_isrv16;
    logic        w_valid;
    logic        w_unused;

    // Upper pc bits only select the line, which the PC generator already did.
    assign w_unused = ^pc[31:3];

    // Freshly returned data is used directly; line_ff covers later cycles.
    assign w_line       = r_rdata_vld ? isram_rdata : r_line_ff;
    assign w_avail      = r_rdata_vld | r_line_vld;
    assign w_slot       = pc[2:1];
    assign w_line_shift = w_line >> {w_slot, 4'b0000};
    assign w_hw         = w_line_shift[15:0];
    assign w_is16       = (w_hw[1:0] != 2'b11);
    assign w_cross      = ~w_is16 & (w_slot == 2'b11);
    assign w_misalign   = pc[0] & w_avail;

    always_comb begin
        w_instr      = NOP_INSTR;
        w_isrv16     = 1'b0;
        w_valid      = 1'b0;
        w_next_state = r_state;
        w_hw_load    = 1'b0;

        if (branch_predict_err) begin
            w_next_state = ST_IDLE;
        end else if (w_misalign) begin
            w_next_state = r_state;
        end else if (r_state == ST_XBD) begin
            // Upper half comes from the new line; the lower half only from hw_buf.
            if (r_rdata_vld) begin
                w_instr      = {isram_rdata[15:0], r_hw_buf};
                w_valid      = 1'b1;
                w_next_state = ST_RUN;
            end
        end else if (w_avail) begin
            // IDLE with data in hand behaves as RUN so the first line is used at once.
            w_next_state = ST_RUN;
            if (w_is16) begin
                w_instr  = {16'h0000, w_hw};
                w_isrv16 = 1'b1;
                w_valid  = 1'b1;
            end else if (!w_cross) begin
                w_instr = w_line_shift[31:0];
                w_valid = 1'b1;
            end else begin
                w_next_state = ST_XBD;
                w_hw_load    = 1'b1;
            end
        end

        // A stall freezes alignment state but leaves the outputs live.
        if (de_stall && !branch_predict_err) begin
            w_next_state = r_state;
            w_hw_load    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge cpurst_n) begin
        if (!cpurst_n) begin
            r_state     <= ST_IDLE;
            r_rdata_vld <= 1'b0;
            r_line_vld  <= 1'b0;
            r_line_ff   <= 64'h0;
            r_hw_buf    <= 16'h0;
        end else begin
            r_rdata_vld <= isram_cs;
            r_state     <= w_next_state;
            if (r_rdata_vld) begin
                r_line_ff <= isram_rdata;
            end
            if (branch_predict_err) begin
                r_line_vld <= 1'b0;
            end else if (r_rdata_vld) begin
                r_line_vld <= 1'b1;
            end
            if (w_hw_load) begin
                r_hw_buf <= w_line[63:48];
            end
        end
    end

    assign rv32_instr     = w_instr;
    assign isrv16         = w_isrv16;
    assign instr_valid    = w_valid;
    assign fetch_misalign = w_misalign;
    assign cross_wait     = (r_state == ST_XBD);

endmodule
